// File: rtl/boid_display_pkg.sv
// -----------------------------------------------------------------------------
// boid_display_pkg
// Shared constants and types for the boid display path (plotter + 1-bit
// double-buffered display memory).
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   X_WIDTH / Y_WIDTH   : boid coordinate widths (unsigned)
//   ADDR_WIDTH          : linear pixel address width (y*SCREEN_W + x)
//   plot_state_t        : plotter FSM state encoding
//   row_base_of()       : start address of a raster row
// -----------------------------------------------------------------------------
package boid_display_pkg;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned X_WIDTH    = 10;
  localparam int unsigned Y_WIDTH    = 9;
  localparam int unsigned ADDR_WIDTH = 19;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_PLOT  = 3'd4,
    ST_SWAP  = 3'd5
  } plot_state_t;

  // Multiply by a constant; synthesis reduces this to a shift-add
  // (640 = 512 + 128 at the default screen width).
  function automatic logic [ADDR_WIDTH-1:0] row_base_of(input logic [Y_WIDTH-1:0] y);
    return ADDR_WIDTH'(y) * ADDR_WIDTH'(SCREEN_W);
  endfunction

endpackage

// File: rtl/boid_plotter_if.sv
// -----------------------------------------------------------------------------
// boid_plotter_if
// Bus bundle between the plotter, the boid position table and the display
// memory write port.
//   boid_rd_idx : table read index               (plotter -> table)
//   boid_x/y    : table read data, 2-cycle latency (table -> plotter)
//   we          : pixel write enable             (plotter -> display memory)
//   write_addr  : pixel address y*SCREEN_W + x   (plotter -> display memory)
//   write_data  : pixel value, 1 when we=1       (plotter -> display memory)
//   swap        : frame-end bank swap pulse      (plotter -> display memory)
// Modports: master = plotter side, slave = table/display-memory side.
// -----------------------------------------------------------------------------
interface boid_plotter_if #(
  parameter int IDX_W = 6
) ();
  import boid_display_pkg::*;

  logic [IDX_W-1:0]      boid_rd_idx;
  logic [X_WIDTH-1:0]    boid_x;
  logic [Y_WIDTH-1:0]    boid_y;
  logic                  we;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  write_data;
  logic                  swap;

  modport master (
    output boid_rd_idx, we, write_addr, write_data, swap,
    input  boid_x, boid_y
  );

  modport slave (
    input  boid_rd_idx, we, write_addr, write_data, swap,
    output boid_x, boid_y
  );

endinterface

// File: rtl/boid_sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// boid_sprite_addr_gen
// Walks one SPRITE x SPRITE square, row-major (dy outer, dx inner), and
// presents the pixel address and clip flag for the current position.
//   clk     : system clock
//   i_load  : capture boid x/y, compute row base, clear dx/dy
//   i_step  : advance to the next pixel of the square
//   i_x/i_y : boid coordinates (sampled on i_load)
//   o_addr  : row_base + x + dx
//   o_en    : pixel lies on screen (x+dx < SCREEN_W and y+dy < SCREEN_H)
//   o_last  : current position is the final pixel of the square
// Holds only datapath state, so it carries no reset: every use is preceded
// by an i_load.
// -----------------------------------------------------------------------------
module boid_sprite_addr_gen
  import boid_display_pkg::*;
#(
  parameter int SPRITE = 2
) (
  input  logic                  clk,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [X_WIDTH-1:0]    i_x,
  input  logic [Y_WIDTH-1:0]    i_y,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_en,
  output logic                  o_last
);

  // SPRITE is at most 4, so a 3-bit counter covers 0..SPRITE without wrap.
  localparam int                CW   = 3;
  localparam logic [CW-1:0]     LAST = CW'(SPRITE - 1);
  localparam logic [X_WIDTH:0]  XLIM = (X_WIDTH + 1)'(SCREEN_W);
  localparam logic [Y_WIDTH:0]  YLIM = (Y_WIDTH + 1)'(SCREEN_H);

  logic [X_WIDTH-1:0]    r_x;
  logic [Y_WIDTH-1:0]    r_y;
  logic [CW-1:0]         r_dx;
  logic [CW-1:0]         r_dy;
  logic [ADDR_WIDTH-1:0] r_row_base;

  logic [X_WIDTH:0]      w_xs;
  logic [Y_WIDTH:0]      w_ys;

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_x        <= i_x;
      r_y        <= i_y;
      r_row_base <= row_base_of(i_y);
      r_dx       <= '0;
      r_dy       <= '0;
    end else if (i_step) begin
      if (r_dx == LAST) begin
        // End of a sprite row: move the base down one raster line.
        r_dx       <= '0;
        r_dy       <= r_dy + CW'(1);
        r_row_base <= r_row_base + ADDR_WIDTH'(SCREEN_W);
      end else begin
        r_dx       <= r_dx + CW'(1);
      end
    end
  end

  // One extra bit on each coordinate sum so the clip compare never wraps
  // for boids sitting at the right/bottom edge.
  assign w_xs   = {1'b0, r_x} + (X_WIDTH + 1)'(r_dx);
  assign w_ys   = {1'b0, r_y} + (Y_WIDTH + 1)'(r_dy);
  assign o_en   = (w_xs < XLIM) && (w_ys < YLIM);
  assign o_addr = r_row_base + ADDR_WIDTH'(r_x) + ADDR_WIDTH'(r_dx);
  assign o_last = (r_dx == LAST) && (r_dy == LAST);

endmodule

// File: rtl/boid_plotter.sv
// -----------------------------------------------------------------------------
// boid_plotter
// On each frame_start, scans the boid position table and writes every boid as
// a SPRITE x SPRITE square of set pixels into the display memory, clipped to
// the screen, then pulses swap so the display memory flips banks.
//   clk         : system clock
//   reset       : synchronous, active-high; aborts any frame in progress
//   frame_start : one-cycle request to plot a new frame
//   bus         : master side of boid_plotter_if (table read + pixel write
//                 port + swap)
//   busy        : frame in progress (cycle after accept through SWAP state)
//   overrun     : sticky, frame_start seen while busy; cleared by reset
// Per-boid cost is fixed: 3 cycles to fetch, plus SPRITE^2 plot cycles when
// the boid's origin is on screen. Clipped pixels still take their cycle.
// we/write_addr/write_data/swap are registered, one cycle behind the FSM.
// -----------------------------------------------------------------------------
module boid_plotter
  import boid_display_pkg::*;
#(
  parameter int NUM_BOIDS      = 64,
  parameter int BOID_IDX_WIDTH = 6,
  parameter int SPRITE         = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  boid_plotter_if.master bus,
  output logic          busy,
  output logic          overrun
);

  localparam logic [BOID_IDX_WIDTH-1:0] LAST_IDX = BOID_IDX_WIDTH'(NUM_BOIDS - 1);

  plot_state_t              r_state;
  logic [BOID_IDX_WIDTH-1:0] r_idx;
  logic                     r_we;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic                     r_wdata;
  logic                     r_swap;
  logic                     r_busy;
  logic                     r_overrun;

  logic                     w_off_screen;
  logic                     w_load;
  logic                     w_step;
  logic [ADDR_WIDTH-1:0]    w_pix_addr;
  logic                     w_pix_en;
  logic                     w_pix_last;

  // The boid origin decides whether the square is plotted at all; partial
  // overhang is handled per pixel by the address generator.
  assign w_off_screen = (bus.boid_x >= X_WIDTH'(SCREEN_W)) ||
                        (bus.boid_y >= Y_WIDTH'(SCREEN_H));
  assign w_load       = (r_state == ST_LOAD);
  assign w_step       = (r_state == ST_PLOT);

  boid_sprite_addr_gen #(
    .SPRITE (SPRITE)
  ) u_addr_gen (
    .clk    (clk),
    .i_load (w_load),
    .i_step (w_step),
    .i_x    (bus.boid_x),
    .i_y    (bus.boid_y),
    .o_addr (w_pix_addr),
    .o_en   (w_pix_en),
    .o_last (w_pix_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 1'b0;
      r_swap    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_wdata <= 1'b0;
      r_swap  <= 1'b0;

      // Any request outside IDLE (SWAP included) is dropped and flagged.
      if (frame_start && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end

        // r_idx is already on boid_rd_idx during FETCH; WAIT covers the
        // second cycle of table latency so data is valid in LOAD.
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT:  r_state <= ST_LOAD;

        ST_LOAD: begin
          if (w_off_screen) begin
            if (r_idx == LAST_IDX) begin
              r_state <= ST_SWAP;
            end else begin
              r_idx   <= r_idx + BOID_IDX_WIDTH'(1);
              r_state <= ST_FETCH;
            end
          end else begin
            r_state <= ST_PLOT;
          end
        end

        ST_PLOT: begin
          r_we    <= w_pix_en;
          r_wdata <= w_pix_en;
          r_addr  <= w_pix_addr;
          if (w_pix_last) begin
            if (r_idx == LAST_IDX) begin
              r_state <= ST_SWAP;
            end else begin
              r_idx   <= r_idx + BOID_IDX_WIDTH'(1);
              r_state <= ST_FETCH;
            end
          end
        end

        ST_SWAP: begin
          r_swap  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.boid_rd_idx = r_idx;
  assign bus.we          = r_we;
  assign bus.write_addr  = r_addr;
  assign bus.write_data  = r_wdata;
  assign bus.swap        = r_swap;
  assign busy            = r_busy;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_boid_plotter.sv
module tb_boid_plotter;

  localparam int NB  = 64;
  localparam int SP  = 2;
  localparam int SW  = 640;
  localparam int SH  = 480;

  typedef struct {
    int addr;
    int cyc;
  } wr_t;

  logic clk;
  logic reset;
  logic frame_start;
  logic busy;
  logic overrun;

  boid_plotter_if #(.IDX_W(6)) bus ();

  boid_plotter #(
    .NUM_BOIDS      (NB),
    .BOID_IDX_WIDTH (6),
    .SPRITE         (SP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bus         (bus),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Boid table with a two-stage registered read.
  int          tbl_x [NB];
  int          tbl_y [NB];
  logic [9:0]  d1x;
  logic [8:0]  d1y;
  always @(posedge clk) begin
    d1x        <= 10'(tbl_x[bus.boid_rd_idx]);
    d1y        <= 9'(tbl_y[bus.boid_rd_idx]);
    bus.boid_x <= d1x;
    bus.boid_y <= d1y;
  end

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t exp_q[$];
  int  swap_q[$];
  int  swaps = 0;
  int  wr_count = 0;
  int  last_swap_tick = 0;
  int  last_frame_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, tick);
    end
  endtask

  // Reference: each boid costs 3 cycles, plus SPRITE^2 if its origin is on
  // screen; pixels are emitted row-major and dropped when off screen. A write
  // caused in frame cycle k is visible k edges after the accepting edge.
  task automatic plan_frame(input int base);
    int c;
    c = 1;
    for (int j = 0; j < NB; j++) begin
      if (tbl_x[j] >= SW || tbl_y[j] >= SH) begin
        c += 3;
      end else begin
        for (int p = 0; p < SP * SP; p++) begin
          int px, py;
          wr_t e;
          px = tbl_x[j] + (p % SP);
          py = tbl_y[j] + (p / SP);
          if (px < SW && py < SH) begin
            e.addr = py * SW + px;
            e.cyc  = base + c + 3 + p;
            exp_q.push_back(e);
          end
        end
        c += 3 + SP * SP;
      end
    end
    swap_q.push_back(base + c);
    last_frame_len = c;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (bus.we) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", int'(bus.write_addr), -1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", int'(bus.write_addr), e.addr);
        check("write_cycle", tick, e.cyc);
        check("write_data_hi", int'(bus.write_data), 1);
      end
    end else begin
      check("write_data_lo", int'(bus.write_data), 0);
    end
    if (bus.swap) begin
      swaps++;
      last_swap_tick = tick;
      if (swap_q.size() == 0) begin
        check("unexpected_swap", tick, -1);
      end else begin
        check("swap_cycle", tick, swap_q.pop_front());
        check("writes_before_swap", exp_q.size(), 0);
      end
    end
  end

  task automatic fill_random(input int mode);
    for (int j = 0; j < NB; j++) begin
      if (mode == 0) begin
        tbl_x[j] = int'($urandom_range(0, SW - SP));
        tbl_y[j] = int'($urandom_range(0, SH - SP));
      end else begin
        tbl_x[j] = int'($urandom_range(0, 1023));
        tbl_y[j] = int'($urandom_range(0, 511));
      end
    end
  endtask

  task automatic start_frame(output int base);
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    base = tick;
    plan_frame(base);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (swaps < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (swaps < target) check("frame_timeout", swaps, target);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int t);
    int n;
    n = 0;
    while (tick != t && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tick != t) check("wait_tick_timeout", tick, t);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int tgt;
    frame_start = 1'b0;
    reset       = 1'b1;
    fill_random(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_idx", int'(bus.boid_rd_idx), 0);
    check("rst_we", int'(bus.we), 0);
    check("rst_write_addr", int'(bus.write_addr), 0);
    check("rst_write_data", int'(bus.write_data), 0);
    check("rst_swap", int'(bus.swap), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    // Directed edge boids followed by mixed random ones.
    fill_random(1);
    tbl_x[0] = 10;  tbl_y[0] = 20;
    tbl_x[1] = 639; tbl_y[1] = 479;
    tbl_x[2] = 638; tbl_y[2] = 478;
    tbl_x[3] = 700; tbl_y[3] = 5;
    tgt = swaps + 1;
    start_frame(base);
    check("busy_in_frame", int'(busy), 1);
    wait_done(tgt);
    check("busy_after_swap", int'(busy), 0);
    check("overrun_clean", int'(overrun), 0);

    // All boids fully on screen: 256 writes, swap 449 edges after accept.
    fill_random(0);
    wr_count = 0;
    tgt = swaps + 1;
    start_frame(base);
    wait_done(tgt);
    check("full_frame_writes", wr_count, NB * SP * SP);
    check("full_frame_len", last_swap_tick - base, 449);

    // frame_start while busy mid-frame.
    fill_random(1);
    tgt = swaps + 1;
    start_frame(base);
    repeat (40) @(posedge clk);
    #1;
    pulse_start();
    check("overrun_set", int'(overrun), 1);
    wait_done(tgt);
    repeat (30) @(posedge clk);
    #1;
    check("overrun_sticky", int'(overrun), 1);
    check("single_swap", swaps, tgt);

    do_reset();
    check("overrun_cleared", int'(overrun), 0);

    // frame_start in the SWAP state counts as overrun and starts nothing.
    fill_random(1);
    tgt = swaps + 1;
    start_frame(base);
    wait_tick(base + last_frame_len - 1);
    pulse_start();
    check("overrun_at_swap", int'(overrun), 1);
    wait_done(tgt);
    repeat (5) @(posedge clk);
    #1;
    check("no_restart_busy", int'(busy), 0);

    do_reset();

    // Reset during the 3rd PLOT cycle of the first boid.
    fill_random(1);
    tbl_x[0] = 10; tbl_y[0] = 20;
    tgt = swaps;
    start_frame(base);
    wait_tick(base + 5);
    reset = 1'b1;
    begin
      wr_t keep[$];
      foreach (exp_q[k]) if (exp_q[k].cyc < base + 6) keep.push_back(exp_q[k]);
      exp_q = keep;
      swap_q.delete();
    end
    @(posedge clk);
    #1;
    check("abort_we", int'(bus.we), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    check("abort_no_swap", swaps, tgt);
    check("abort_busy", int'(busy), 0);

    // Full frames after the abort.
    fill_random(1);
    tgt = swaps + 1;
    start_frame(base);
    wait_done(tgt);
    check("post_abort_busy", int'(busy), 0);

    fill_random(0);
    tgt = swaps + 1;
    start_frame(base);
    wait_done(tgt);
    check("post_abort_len", last_swap_tick - base, 449);

    repeat (5) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("swap_q_drained", swap_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
